// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter with a hardware return-address stack.
// Selects increment, branch, call (push) or return (pop) each cycle.
module pc_stack_unit #(
  parameter int AW         = 9,
  parameter int DEPTH      = 8,
  parameter int RESET_ADDR = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       br_en,
  input  logic [AW-1:0]              br_target,
  input  logic                       call_en,
  input  logic [AW-1:0]              call_target,
  input  logic                       ret_en,
  output logic [AW-1:0]              pc_out,
  output logic [$clog2(DEPTH+1)-1:0] stk_count,
  output logic                       stk_full,
  output logic                       stk_empty,
  output logic                       stk_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [AW-1:0] RST_PC   = AW'(RESET_ADDR);

  logic [AW-1:0] mem [DEPTH];

  logic [AW-1:0] pc_inc;
  logic [AW-1:0] pc_nxt;
  logic [AW-1:0] top;
  logic [CW-1:0] cnt_nxt;
  logic [PW-1:0] wr_idx;
  logic [PW-1:0] rd_idx;
  logic          err_nxt;
  logic          push;

  logic sel_ret;
  logic sel_call;
  logic sel_br;
  logic sel_inc;

  assign pc_inc = pc_out + AW'(1);

  // Slot above the top is the push slot; top entry sits one below it.
  assign wr_idx = PW'(stk_count);
  assign rd_idx = PW'(stk_count - CW'(1));
  assign top    = mem[rd_idx];

  assign stk_full  = (stk_count == FULL_CNT);
  assign stk_empty = (stk_count == '0);

  // One-hot request select: stall > ret > call > br > increment.
  assign sel_ret  = ~stall & ret_en;
  assign sel_call = ~stall & ~ret_en & call_en;
  assign sel_br   = ~stall & ~ret_en & ~call_en & br_en;
  assign sel_inc  = ~stall & ~ret_en & ~call_en & ~br_en;

  // A call on a full stack still jumps but drops its return address.
  assign push = sel_call & ~stk_full;

  // Next PC, stack depth and error flag from the selected request.
  always_comb begin
    pc_nxt  = pc_out;
    cnt_nxt = stk_count;
    err_nxt = stk_err;
    unique case (1'b1)
      sel_ret: begin
        if (stk_empty) begin
          pc_nxt  = pc_inc;
          err_nxt = 1'b1;
        end else begin
          pc_nxt  = top;
          cnt_nxt = stk_count - CW'(1);
        end
      end
      sel_call: begin
        pc_nxt = call_target;
        if (stk_full) begin
          err_nxt = 1'b1;
        end else begin
          cnt_nxt = stk_count + CW'(1);
        end
      end
      sel_br: begin
        pc_nxt = br_target;
      end
      sel_inc: begin
        pc_nxt = pc_inc;
      end
      default: begin
        pc_nxt = pc_out;
      end
    endcase
  end

  // PC, depth and sticky error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_out    <= RST_PC;
      stk_count <= '0;
      stk_err   <= 1'b0;
    end else begin
      pc_out    <= pc_nxt;
      stk_count <= cnt_nxt;
      stk_err   <= err_nxt;
    end
  end

  // Return-address storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_idx] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit: vector table, corner sequences and
// randomized run against a queue-based reference model.
module tb_pc_stack_unit;

  localparam int AW    = 9;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int MOD   = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic          br_en;
  logic [AW-1:0] br_target;
  logic          call_en;
  logic [AW-1:0] call_target;
  logic          ret_en;
  logic [AW-1:0] pc_out;
  logic [CW-1:0] stk_count;
  logic          stk_full;
  logic          stk_empty;
  logic          stk_err;

  int tests = 0;
  int fails = 0;

  pc_stack_unit #(
    .AW(AW),
    .DEPTH(DEPTH),
    .RESET_ADDR(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .br_en(br_en),
    .br_target(br_target),
    .call_en(call_en),
    .call_target(call_target),
    .ret_en(ret_en),
    .pc_out(pc_out),
    .stk_count(stk_count),
    .stk_full(stk_full),
    .stk_empty(stk_empty),
    .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic     stall;
    logic     br;
    int       bt;
    logic     call;
    int       ct;
    logic     ret;
    int       pc;
    int       cnt;
    logic     err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_state(input string nm, input int pc,
                             input int cnt, input int err);
    check({nm, " pc"}, int'(pc_out), pc);
    check({nm, " count"}, int'(stk_count), cnt);
    check({nm, " full"}, int'(stk_full), int'(cnt == DEPTH));
    check({nm, " empty"}, int'(stk_empty), int'(cnt == 0));
    check({nm, " err"}, int'(stk_err), err);
  endtask

  task automatic drive(input logic s, input logic b, input int bt,
                       input logic c, input int ct, input logic r);
    stall       = s;
    br_en       = b;
    br_target   = AW'(bt);
    call_en     = c;
    call_target = AW'(ct);
    ret_en      = r;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic add(input logic s, input logic b, input int bt,
                     input logic c, input int ct, input logic r,
                     input int pc, input int cnt, input logic err);
    vec_t v;
    v.stall = s; v.br = b; v.bt = bt; v.call = c; v.ct = ct;
    v.ret = r; v.pc = pc; v.cnt = cnt; v.err = err;
    vecs.push_back(v);
  endtask

  // Reference model state.
  int m_pc;
  int m_err;
  int m_stk[$];

  task automatic model_step(input logic s, input logic b, input int bt,
                            input logic c, input int ct, input logic r);
    if (s) return;
    if (r) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else begin
        m_pc  = (m_pc + 1) % MOD;
        m_err = 1;
      end
    end else if (c) begin
      if (m_stk.size() < DEPTH) m_stk.push_back((m_pc + 1) % MOD);
      else m_err = 1;
      m_pc = ct;
    end else if (b) begin
      m_pc = bt;
    end else begin
      m_pc = (m_pc + 1) % MOD;
    end
  endtask

  int tgt[9];
  int pushed[9];

  initial begin
    rst = 1'b1;
    idle();
    #2;
    check_state("reset", 0, 0, 0);

    // Table: from reset, increment, nested calls, wrap, priority.
    add(0, 0, 0,     0, 0,     0, 'h001, 0, 0);
    add(0, 0, 0,     0, 0,     0, 'h002, 0, 0);
    add(0, 0, 0,     0, 0,     0, 'h003, 0, 0);
    add(0, 0, 0,     1, 'h40,  0, 'h040, 1, 0);
    add(0, 0, 0,     0, 0,     0, 'h041, 1, 0);
    add(0, 0, 0,     1, 'h80,  0, 'h080, 2, 0);
    add(0, 0, 0,     0, 0,     1, 'h042, 1, 0);
    add(0, 0, 0,     0, 0,     1, 'h004, 0, 0);
    add(0, 1, 'h1FE, 0, 0,     0, 'h1FE, 0, 0);
    add(0, 0, 0,     0, 0,     0, 'h1FF, 0, 0);
    add(0, 0, 0,     0, 0,     0, 'h000, 0, 0);
    add(0, 0, 0,     1, 'h10,  0, 'h010, 1, 0);
    add(1, 1, 'h30,  1, 'h20,  1, 'h010, 1, 0);
    add(0, 1, 'h30,  1, 'h20,  1, 'h001, 0, 0);
    add(0, 1, 'h77,  1, 'h99,  0, 'h099, 1, 0);
    add(0, 0, 0,     0, 0,     1, 'h002, 0, 0);
    add(0, 0, 0,     0, 0,     1, 'h003, 0, 1);
    add(1, 0, 0,     0, 0,     0, 'h003, 0, 1);

    @(negedge clk);
    rst = 1'b0;
    foreach (vecs[i]) begin
      drive(vecs[i].stall, vecs[i].br, vecs[i].bt,
            vecs[i].call, vecs[i].ct, vecs[i].ret);
      tick();
      check_state($sformatf("vec%0d", i),
                  vecs[i].pc, vecs[i].cnt, int'(vecs[i].err));
    end

    // Overflow then full unwind and underflow.
    do_reset();
    for (int i = 0; i < 9; i++) tgt[i] = 'h10 + 'h20 * i;
    pushed[0] = 1;
    for (int i = 1; i < 9; i++) pushed[i] = tgt[i-1] + 1;
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 1'b0, 0, 1'b1, tgt[i], 1'b0);
      tick();
      check_state($sformatf("ovf call%0d", i), tgt[i],
                  (i < DEPTH) ? i + 1 : DEPTH, int'(i == 8));
    end
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b0, 1'b0, 0, 1'b0, 0, 1'b1);
      tick();
      check_state($sformatf("unwind ret%0d", k),
                  pushed[DEPTH-1-k], DEPTH - 1 - k, 1);
    end
    drive(1'b0, 1'b0, 0, 1'b0, 0, 1'b1);
    tick();
    check_state("udf ret", pushed[0] + 1, 0, 1);

    // Asynchronous reset between edges.
    do_reset();
    drive(1'b0, 1'b0, 0, 1'b0, 0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 0, 1'b1, 'h100, 1'b0);
    tick();
    drive(1'b0, 1'b0, 0, 1'b1, 'h110, 1'b0);
    tick();
    drive(1'b0, 1'b0, 0, 1'b1, 'h053, 1'b0);
    tick();
    idle();
    tick();
    tick();
    check_state("pre async", 'h55, 3, 1);
    #2;
    rst = 1'b1;
    #1;
    check_state("async rst", 0, 0, 0);
    #2;
    rst = 1'b0;
    tick();
    check_state("post async", 1, 0, 0);

    // Randomized run against the reference model.
    do_reset();
    m_pc = 0;
    m_err = 0;
    m_stk.delete();
    for (int n = 0; n < 3000; n++) begin
      logic s, b, c, r;
      int bt, ct;
      s  = ($urandom_range(0, 9) == 0);
      b  = ($urandom_range(0, 3) == 0);
      c  = ($urandom_range(0, 2) == 0);
      r  = ($urandom_range(0, 2) == 0);
      bt = $urandom_range(0, MOD - 1);
      ct = $urandom_range(0, MOD - 1);
      drive(s, b, bt, c, ct, r);
      tick();
      model_step(s, b, bt, c, ct, r);
      check_state($sformatf("rand%0d", n), m_pc, m_stk.size(), m_err);
      if (n == 1500 && m_err == 1) begin
        do_reset();
        m_pc = 0;
        m_err = 0;
        m_stk.delete();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
